// File: rtl/panda_risc_v_ifu_fetch_ctrl.sv
// IFU fetch control: owns the fetch PC, runs one ibus fetch at a time (REQ->WAIT->OUT, 3 cycles/insn at zero wait).
// Backpressure: cmd held stable until ibus_cmd_ready; fetched word held in OUT until if_ready or a flush drops it.
module panda_risc_v_ifu_fetch_ctrl #(
  parameter int SIM_DELAY = 1
) (
  input  logic        clk,
  input  logic        sys_resetn,
  output logic [31:0] now_pc,
  input  logic [31:0] new_pc,
  output logic        to_rst,
  output logic        to_flush,
  output logic [31:0] flush_addr_hold,
  input  logic        prdt_jump,
  input  logic        flush_req,
  input  logic [31:0] flush_addr,
  output logic [31:0] ibus_cmd_addr,
  output logic        ibus_cmd_valid,
  input  logic        ibus_cmd_ready,
  input  logic [31:0] ibus_rsp_rdata,
  input  logic        ibus_rsp_err,
  input  logic        ibus_rsp_valid,
  output logic        ibus_rsp_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_err,
  output logic        if_prdt_jump,
  output logic        if_valid,
  input  logic        if_ready
);

  typedef enum logic [1:0] {ST_RST, ST_REQ, ST_WAIT, ST_OUT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_now_pc, w_now_pc_nxt;
  logic [31:0] r_if_inst, w_if_inst_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic        r_if_err, w_if_err_nxt;
  logic [31:0] r_flush_addr, w_flush_addr_nxt;
  logic        r_flush_pend, w_flush_pend_nxt;

  // Delay parameter exists only for legacy simulation compatibility.
  logic w_unused_sim_delay;
  assign w_unused_sim_delay = (SIM_DELAY != 0);

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state      <= ST_RST;
      r_now_pc     <= 32'd0;
      r_if_inst    <= 32'd0;
      r_if_pc      <= 32'd0;
      r_if_err     <= 1'b0;
      r_flush_addr <= 32'd0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_now_pc     <= w_now_pc_nxt;
      r_if_inst    <= w_if_inst_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_err     <= w_if_err_nxt;
      r_flush_addr <= w_flush_addr_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_now_pc_nxt     = r_now_pc;
    w_if_inst_nxt    = r_if_inst;
    w_if_pc_nxt      = r_if_pc;
    w_if_err_nxt     = r_if_err;
    w_flush_addr_nxt = r_flush_addr;
    w_flush_pend_nxt = r_flush_pend;
    case (r_state)
      ST_RST: begin
        w_now_pc_nxt = new_pc;
        w_state_nxt  = ST_REQ;
      end
      ST_REQ: begin
        if (flush_req) begin
          w_flush_addr_nxt = flush_addr;
          w_flush_pend_nxt = 1'b1;
        end
        if (ibus_cmd_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush_req) w_flush_addr_nxt = flush_addr;
        if (ibus_rsp_valid) begin
          // A flush arriving with the response still kills that word.
          if (r_flush_pend || flush_req) begin
            w_now_pc_nxt     = new_pc;
            w_flush_pend_nxt = 1'b0;
            w_state_nxt      = ST_REQ;
          end else begin
            w_if_inst_nxt = ibus_rsp_rdata;
            w_if_err_nxt  = ibus_rsp_err;
            w_if_pc_nxt   = r_now_pc;
            w_state_nxt   = ST_OUT;
          end
        end else if (flush_req) begin
          w_flush_pend_nxt = 1'b1;
        end
      end
      ST_OUT: begin
        if (flush_req) begin
          w_now_pc_nxt = flush_addr;
          w_state_nxt  = ST_REQ;
        end else if (if_ready) begin
          w_now_pc_nxt = new_pc;
          w_state_nxt  = ST_REQ;
        end
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  assign now_pc          = r_now_pc;
  assign to_rst          = (r_state == ST_RST);
  assign to_flush        = flush_req | r_flush_pend;
  assign flush_addr_hold = flush_req ? flush_addr : r_flush_addr;
  assign ibus_cmd_addr   = r_now_pc;
  assign ibus_cmd_valid  = (r_state == ST_REQ);
  assign ibus_rsp_ready  = (r_state == ST_WAIT);
  assign if_inst         = r_if_inst;
  assign if_pc           = r_if_pc;
  assign if_err          = r_if_err;
  assign if_prdt_jump    = prdt_jump;
  assign if_valid        = (r_state == ST_OUT);

endmodule
